// File: rtl/score_display_if.sv
// score_display_if: groups the score/tick inputs and display outputs of score_display.
//   ScanTick   : one-cycle pulse, advances the scanned digit
//   BlinkTick  : one-cycle pulse, toggles the game-over blink phase
//   Score      : unsigned binary score
//   ScoreValid : one-cycle request to display Score
//   GameOver   : level, enables blinking
//   Seg        : segments {g,f,e,d,c,b,a}, active-low
//   Dp         : decimal point, active-low (always off)
//   An         : digit anodes, active-low, An[0] is the ones digit
//   Busy       : BCD conversion in progress
// master drives the requests (game logic / divider), slave is the display driver.
interface score_display_if #(
    parameter int unsigned ScoreWidth = 14
);
    logic                  ScanTick;
    logic                  BlinkTick;
    logic [ScoreWidth-1:0] Score;
    logic                  ScoreValid;
    logic                  GameOver;
    logic [6:0]            Seg;
    logic                  Dp;
    logic [3:0]            An;
    logic                  Busy;

    modport master (
        output ScanTick, BlinkTick, Score, ScoreValid, GameOver,
        input  Seg, Dp, An, Busy
    );

    modport slave (
        input  ScanTick, BlinkTick, Score, ScoreValid, GameOver,
        output Seg, Dp, An, Busy
    );
endinterface

// File: rtl/score_display.sv
// score_display: four-digit common-anode seven-segment driver for the snake board.
// A binary score is saturated to MaxScore, converted to BCD by a sequential
// double-dabble engine (one shift per cycle), and the resulting digits are
// scanned onto the anodes with leading-zero blanking and a game-over blink.
// Ports:
//   MasterClock : system clock, rising edge
//   Reset       : synchronous, active-high
//   bus         : score_display_if slave (ticks, score request, segment/anode outputs, Busy)
module score_display #(
    parameter int unsigned MaxScore  = 9999,
    parameter int unsigned ConvSteps = 14
) (
    input  logic           MasterClock,
    input  logic           Reset,
    score_display_if.slave bus
);
    localparam int unsigned StepW = $clog2(ConvSteps + 1);

    typedef enum logic [1:0] {StIdle, StShift, StLoad} state_e;

    state_e               state_q, state_d;
    logic [ConvSteps-1:0] bin_q, bin_d;
    logic [15:0]          bcd_q, bcd_d;
    logic [StepW-1:0]     step_q, step_d;
    logic                 pend_vld_q, pend_vld_d;
    logic [ConvSteps-1:0] pend_q, pend_d;
    logic [15:0]          digits_q, digits_d;
    logic [1:0]           scan_q, scan_d;
    logic                 phase_q, phase_d;
    logic [6:0]           seg_q, seg_d;
    logic [3:0]           an_q, an_d;

    logic [15:0]          bcd_adj;
    logic [3:0]           digit;
    logic                 blank;

    function automatic logic [ConvSteps-1:0] saturate(input logic [ConvSteps-1:0] v);
        if (32'(v) > MaxScore) return ConvSteps'(MaxScore);
        return v;
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Double-dabble correction: any nibble >= 5 would overflow past 9 after the shift.
    always_comb begin
        bcd_adj = '0;
        for (int k = 0; k < 4; k++) begin
            bcd_adj[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? bcd_q[4*k +: 4] + 4'd3
                                                            : bcd_q[4*k +: 4];
        end
    end

    // Conversion FSM and pending request.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        step_d     = step_q;
        pend_vld_d = pend_vld_q;
        pend_d     = pend_q;
        digits_d   = digits_q;

        unique case (state_q)
            StIdle: begin
                if (bus.ScoreValid) begin
                    state_d = StShift;
                    bin_d   = saturate(bus.Score);
                    bcd_d   = '0;
                    step_d  = '0;
                end
            end
            StShift: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                step_d         = step_q + 1'b1;
                if (step_q == StepW'(ConvSteps - 1)) begin
                    state_d = StLoad;
                end
                if (bus.ScoreValid) begin
                    pend_vld_d = 1'b1;
                    pend_d     = bus.Score;
                end
            end
            StLoad: begin
                digits_d   = bcd_q;
                pend_vld_d = 1'b0;
                bcd_d      = '0;
                step_d     = '0;
                // A request arriving on the LOAD edge is newer than the pending one.
                if (bus.ScoreValid) begin
                    state_d = StShift;
                    bin_d   = saturate(bus.Score);
                end else if (pend_vld_q) begin
                    state_d = StShift;
                    bin_d   = saturate(pend_q);
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Scan index, blink phase and registered display outputs.
    always_comb begin
        scan_d  = scan_q + {1'b0, bus.ScanTick};
        phase_d = bus.GameOver ? (phase_q ^ bus.BlinkTick) : 1'b0;

        digit = digits_q[{scan_q, 2'b00} +: 4];

        // Leading-zero blanking: a digit is dark only if it and all higher digits are zero.
        case (scan_q)
            2'd3:    blank = (digits_q[15:12] == 4'd0);
            2'd2:    blank = (digits_q[15:8] == 8'd0);
            2'd1:    blank = (digits_q[15:4] == 12'd0);
            default: blank = 1'b0;
        endcase

        an_d  = (blank || phase_q) ? 4'b1111 : ~(4'b0001 << scan_q);
        seg_d = decode(digit);
    end

    always_ff @(posedge MasterClock) begin
        if (Reset) begin
            state_q    <= StIdle;
            bin_q      <= '0;
            bcd_q      <= '0;
            step_q     <= '0;
            pend_vld_q <= 1'b0;
            pend_q     <= '0;
            digits_q   <= '0;
            scan_q     <= 2'd0;
            phase_q    <= 1'b0;
            seg_q      <= 7'b1111111;
            an_q       <= 4'b1111;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            step_q     <= step_d;
            pend_vld_q <= pend_vld_d;
            pend_q     <= pend_d;
            digits_q   <= digits_d;
            scan_q     <= scan_d;
            phase_q    <= phase_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign bus.Seg  = seg_q;
    assign bus.An   = an_q;
    assign bus.Dp   = 1'b1;
    assign bus.Busy = (state_q != StIdle);
endmodule

// File: tb/tb_score_display.sv
// tb_score_display: self-checking bench for score_display. Expected digits come from
// decimal arithmetic on min(score, 9999); expected anodes/segments from a digit table.
module tb_score_display;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    score_display_if bus ();

    score_display #(.MaxScore(9999), .ConvSteps(14)) dut (
        .MasterClock(clk),
        .Reset      (rst),
        .bus        (bus)
    );

    typedef struct {
        int score;
        int shown;
        bit scan_at_load;
    } vec_t;

    int         nchecks = 0;
    int         nfail   = 0;
    int         idx     = 0;   // model scan index
    int         shown   = 0;   // model displayed value
    int         pow10[4];
    logic [6:0] segtab[10];
    vec_t       vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_an(input int val, input int k);
        logic [3:0] one;
        one = 4'b0001;
        if (k > 0 && val < pow10[k]) return 4'b1111;
        return ~(one << k);
    endfunction

    task automatic check_display(input string tag);
        logic [3:0] a;
        a = exp_an(shown, idx);
        chk($sformatf("%s an slot%0d val%0d", tag, idx, shown), {28'd0, bus.An}, {28'd0, a});
        if (a != 4'b1111)
            chk($sformatf("%s seg slot%0d val%0d", tag, idx, shown), {25'd0, bus.Seg},
                {25'd0, segtab[(shown / pow10[idx]) % 10]});
        chk($sformatf("%s dp", tag), {31'd0, bus.Dp}, 32'd1);
    endtask

    task automatic scan_one(input bit check);
        bus.ScanTick = 1'b1;
        tick();
        bus.ScanTick = 1'b0;
        idx = (idx + 1) % 4;
        tick();
        if (check) check_display("scan");
    endtask

    task automatic convert(input int score, input bit scan_at_load);
        int n;
        bus.Score      = 14'(score);
        bus.ScoreValid = 1'b1;
        tick();
        bus.ScoreValid = 1'b0;
        n = 0;
        while (bus.Busy && n < 100) begin
            n++;
            if (scan_at_load && n == 15) bus.ScanTick = 1'b1;
            tick();
            bus.ScanTick = 1'b0;
        end
        chk($sformatf("busy cycles score%0d", score), n, 15);
        if (scan_at_load) idx = (idx + 1) % 4;
        shown = (score > 9999) ? 9999 : score;
        tick();
        check_display("after load");
        for (int i = 0; i < 4; i++) scan_one(1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int seen2;
        pow10[0] = 1; pow10[1] = 10; pow10[2] = 100; pow10[3] = 1000;
        segtab[0] = 7'b1000000; segtab[1] = 7'b1111001; segtab[2] = 7'b0100100;
        segtab[3] = 7'b0110000; segtab[4] = 7'b0011001; segtab[5] = 7'b0010010;
        segtab[6] = 7'b0000010; segtab[7] = 7'b1111000; segtab[8] = 7'b0000000;
        segtab[9] = 7'b0010000;

        vecs[0] = '{1234, 1234, 1'b0};
        vecs[1] = '{57, 57, 1'b0};
        vecs[2] = '{16383, 9999, 1'b0};
        vecs[3] = '{0, 0, 1'b0};
        vecs[4] = '{10000, 9999, 1'b1};
        vecs[5] = '{9999, 9999, 1'b0};
        vecs[6] = '{1000, 1000, 1'b1};
        vecs[7] = '{5080, 5080, 1'b0};
        vecs[8] = '{9, 9, 1'b0};
        vecs[9] = '{601, 601, 1'b1};

        bus.ScanTick = 0; bus.BlinkTick = 0; bus.Score = '0;
        bus.ScoreValid = 0; bus.GameOver = 0;
        rst = 1'b1;
        tick();
        tick();
        chk("reset an", {28'd0, bus.An}, 32'hF);
        chk("reset seg", {25'd0, bus.Seg}, 32'h7F);
        chk("reset dp", {31'd0, bus.Dp}, 32'd1);
        chk("reset busy", {31'd0, bus.Busy}, 32'd0);
        rst = 1'b0;
        tick();
        check_display("post reset");
        for (int i = 0; i < 4; i++) scan_one(1'b1);

        // Table vectors: expected shown value is a hand-written constant.
        foreach (vecs[i]) begin
            convert(vecs[i].score, vecs[i].scan_at_load);
            chk($sformatf("table shown %0d", i), shown, vecs[i].shown);
        end

        // Random scores against the min(score, MaxScore) model.
        for (int i = 0; i < 12; i++) convert(int'($urandom_range(0, 16383)), 1'(i % 3 == 0));

        // Back-to-back: 100, then 200 and 300 while busy; 300 must win.
        convert(16383, 1'b0);
        while (idx != 2) scan_one(1'b0);
        bus.Score = 14'd100;
        bus.ScoreValid = 1'b1;
        tick();
        bus.ScoreValid = 1'b0;
        n = 0;
        seen2 = 0;
        while (bus.Busy && n < 100) begin
            n++;
            if (bus.An == 4'b1011 && bus.Seg == segtab[2]) seen2++;
            if (n == 17) begin
                chk("b2b first value an", {28'd0, bus.An}, 32'hB);
                chk("b2b first value seg", {25'd0, bus.Seg}, {25'd0, segtab[1]});
            end
            bus.ScoreValid = (n == 3 || n == 6);
            bus.Score      = (n == 3) ? 14'd200 : 14'd300;
            tick();
            bus.ScoreValid = 1'b0;
        end
        chk("b2b busy cycles", n, 30);
        tick();
        chk("b2b 200 never shown", seen2, 0);
        shown = 300;
        check_display("b2b final");

        // Blink.
        while (idx != 0) scan_one(1'b1);
        bus.GameOver = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            bus.BlinkTick = 1'b1;
            tick();
            bus.BlinkTick = 1'b0;
            tick();
            if (t % 2 == 1) chk($sformatf("blink dark tick%0d", t), {28'd0, bus.An}, 32'hF);
            else check_display("blink lit");
        end
        bus.GameOver = 1'b0;
        tick();
        tick();
        check_display("gameover off");
        bus.GameOver = 1'b1;
        tick();
        bus.GameOver  = 1'b0;
        bus.BlinkTick = 1'b1;
        tick();
        bus.BlinkTick = 1'b0;
        tick();
        check_display("blink with gameover drop");

        // ScanTick on consecutive cycles advances twice.
        convert(4321, 1'b0);
        bus.ScanTick = 1'b1;
        tick();
        tick();
        bus.ScanTick = 1'b0;
        idx = (idx + 2) % 4;
        tick();
        check_display("double scan");

        // Reset mid-conversion with a pending request: both lost.
        bus.Score = 14'd4321;
        bus.ScoreValid = 1'b1;
        tick();
        bus.Score = 14'd777;
        tick();
        bus.ScoreValid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid reset busy", {31'd0, bus.Busy}, 32'd0);
        chk("mid reset an", {28'd0, bus.An}, 32'hF);
        idx = 0;
        shown = 0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.Busy) n++;
        end
        chk("pending lost busy", n, 0);
        check_display("mid reset digits");
        for (int i = 0; i < 4; i++) scan_one(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
        $finish;
    end
endmodule

// File: doc/score_display.md
# score_display

Drives the four-digit, common-anode seven-segment display of the snake board. It sits directly downstream of the clock divider. The divider's fast display tick advances the digit scan and its 2 Hz game tick paces the game-over blink. A binary score arriving from game logic is converted to BCD by a sequential double-dabble engine, then multiplexed onto the segment and anode pins with leading-zero blanking.

## Interface
- MaxScore, 9999: saturation limit for Score; values above it display as MaxScore.
- ConvSteps, 14: shift steps per conversion, equal to the width of Score.

- MasterClock  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- ScanTick  in  1  one-cycle pulse from the divider's fast tick; advances the scan digit.
- BlinkTick  in  1  one-cycle pulse from the divider's 2 Hz game tick; toggles the blink phase.
- Score  in  14  unsigned binary score.
- ScoreValid  in  1  one-cycle request to display Score.
- GameOver  in  1  level; enables blinking.
- Seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- Dp  out  1  decimal point, active-low; held 1 (off).
- An  out  4  digit anodes, active-low; An[0] is the ones digit.
- Busy  out  1  conversion in progress.

## Operation
- Conversion FSM has three states: IDLE, SHIFT and LOAD.
  - IDLE to SHIFT: on ScoreValid. Latch min(Score, MaxScore) into the shift register and clear the 16-bit BCD accumulator.
  - SHIFT: each cycle, add 3 to every BCD nibble that is ≥5, then shift {bcd, bin} left by 1. After ConvSteps shifts, go to LOAD.
  - LOAD: copy the BCD nibbles into the display digit registers D3..D0. Go to IDLE, or straight back to SHIFT if a request is pending.
- Pending request: ScoreValid while not in IDLE stores Score in a one-deep pending register. A later request overwrites it (last wins). The pending request is consumed in LOAD.
- Display digits keep their old value until LOAD, so the display never shows a partial conversion.
- Scan: a 2-bit index advances 0→1→2→3→0 on each ScanTick and holds otherwise.
- Blanking: digit k (k = 3, 2, 1) is blanked when Dk = 0 and every higher digit is also 0. D0 is never blanked.
  - A blanked digit drives An = 4'b1111 for its slot.
- Blink:
  - The phase register toggles on BlinkTick while GameOver = 1.
  - It is forced to 0 while GameOver = 0.
  - While phase = 1, An = 4'b1111.
- Decoder, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any other code gives 1111111.

## Timing
- Reset values:
  - Outputs: An=1111, Seg=1111111, Dp=1, Busy=0.
  - Internal: FSM=IDLE, D3..D0=0, scan index=0, blink phase=0, pending cleared.
- Reset mid-conversion aborts the conversion. The digits read 0 and the pending request is lost.
- Conversion latency, with ScoreValid sampled on edge E0:
  - Busy=1 after E0.
  - Shifts occur on E1..E14.
  - LOAD occurs on E15, where D3..D0 update and Busy returns to 0 unless a pending request restarts the FSM.
  - Total is 15 cycles from request to digit update.
- Back-to-back: with a pending request, Busy stays 1 through LOAD and the next SHIFT begins at E16.
- An, Seg and Dp are registered. They reflect the new scan index and the current digits one cycle after the ScanTick edge, and are stable between ticks.
- Scan boundaries:
  - ScanTick and LOAD on the same edge: the index advances and the display uses the new digits from the next edge.
  - ScanTick asserted on consecutive cycles: each one advances the index.
- BlinkTick and a GameOver deassertion on the same edge: the phase goes to 0.

## Test plan
- Reset, then 4 ScanTicks with no score → An sequence 1110, 1101, 1011, 0111 restricted to active digits. Only An=1110 with Seg=1000000 is driven; the other slots give An=1111.
- Score=1234, ScoreValid → Busy is 1 for exactly 15 cycles. Scan then shows D0=4 (0011001), D1=3, D2=2, D3=1 (1111001) on An=1110/1101/1011/0111.
- Score=57 → D1=5 and D0=7 are shown. Slots 2 and 3 give An=1111.
- Score=16383 → saturates and displays 9999 (Seg=0010000 on every digit).
- ScoreValid with 100, then 200 and 300 during Busy → display goes 100 then 300. 200 never appears, and Busy stays high continuously for 30 cycles.
- GameOver=1 then 3 BlinkTicks → An is forced to 1111 after ticks 1 and 3 and restored after tick 2. GameOver=0 restores normal scan immediately. A Reset asserted mid-conversion yields 0 and Busy=0 on the next cycle.
